// File: rtl/pipe_reg.sv
// DEPTH-stage elastic pipeline register with valid/ready on both sides, bubble
// collapsing, stall hold and synchronous flush. Define PIPE_REG_OCC_EN for the occupancy port.
module pipe_reg #(
    parameter int unsigned           WIDTH = 32,
    parameter int unsigned           DEPTH = 2,
    parameter logic [WIDTH-1:0]      INIT  = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef PIPE_REG_OCC_EN
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
`endif
    output logic [WIDTH-1:0]           out_data
);

    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v_r;
    logic [WIDTH-1:0] d_r [DEPTH];
    logic [DEPTH:0]   v_pad_s;
    logic [DEPTH-1:0] adv_s;
    logic [DEPTH-1:0] v_nxt_s;
    logic             acc_s;
    logic             in_ready_s;

    // Advance chain: each stage leaves when the stage ahead is empty or leaving itself.
    always_comb begin
        logic go;
        go      = 1'b0;
        adv_s   = {DEPTH{1'b0}};
        v_pad_s = {1'b0, v_r};
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (k == DEPTH - 1) begin
                go = v_r[k] & out_ready;
            end else begin
                go = v_r[k] & (~v_pad_s[k+1] | go);
            end
            adv_s[k] = go;
        end
        in_ready_s = ~v_r[0] | adv_s[0];
        acc_s      = in_valid & in_ready_s;
    end

    // Next valid bits: filled from behind, or kept when not leaving.
    always_comb begin
        v_nxt_s    = {DEPTH{1'b0}};
        v_nxt_s[0] = acc_s | (v_r[0] & ~adv_s[0]);
        for (int k = 1; k < DEPTH; k++) begin
            v_nxt_s[k] = adv_s[k-1] | (v_r[k] & ~adv_s[k]);
        end
    end

    // Stage valid and data registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            v_r <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                d_r[k] <= INIT;
            end
        end else if (flush) begin
            v_r <= {DEPTH{1'b0}};
        end else begin
            v_r <= v_nxt_s;
            if (acc_s) begin
                d_r[0] <= in_data;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv_s[k-1]) begin
                    d_r[k] <= d_r[k-1];
                end
            end
        end
    end

`ifdef PIPE_REG_OCC_EN
    logic [OCC_W-1:0] occ_r;

    // Occupancy counter tracking the popcount of the valid bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            occ_r <= {OCC_W{1'b0}};
        end else if (flush) begin
            occ_r <= {OCC_W{1'b0}};
        end else if (acc_s && !adv_s[DEPTH-1]) begin
            occ_r <= occ_r + OCC_W'(1);
        end else if (!acc_s && adv_s[DEPTH-1]) begin
            occ_r <= occ_r - OCC_W'(1);
        end else begin
            occ_r <= occ_r;
        end
    end

    assign occupancy = occ_r;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = v_r[DEPTH-1];
    assign out_data  = d_r[DEPTH-1];

endmodule
